// File: rtl/intersection_pkg.sv
// intersection_pkg: shared lamp encodings, controller states and small
// helpers for the four-approach intersection phase arbiter.
package intersection_pkg;

  localparam int N_APPROACH = 4;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  // All four approaches red: the lamp word held through reset and all-red.
  localparam logic [3*N_APPROACH-1:0] LIGHTS_RESET = 12'h924;

  typedef enum logic [1:0] {
    ST_ALLRED = 2'd0,
    ST_GREEN  = 2'd1,
    ST_YELLOW = 2'd2
  } phase_state_t;

  // One-hot mask of an approach number.
  function automatic logic [N_APPROACH-1:0] phase_onehot(input logic [1:0] ph);
    return 4'b0001 << ph;
  endfunction

  // Lamp word for a controller state: the owning approach shows green or
  // yellow, every other approach (and every approach in all-red) shows red.
  function automatic logic [3*N_APPROACH-1:0] make_lights(input phase_state_t st,
                                                          input logic [1:0]   ph);
    logic [3*N_APPROACH-1:0] l;
    l = LIGHTS_RESET;
    for (int i = 0; i < N_APPROACH; i++) begin
      if ((st == ST_GREEN) && (ph == 2'(i))) begin
        l[3*i +: 3] = LIGHT_GREEN;
      end else if ((st == ST_YELLOW) && (ph == 2'(i))) begin
        l[3*i +: 3] = LIGHT_YELLOW;
      end else begin
        l[3*i +: 3] = LIGHT_RED;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/intersection_phase_arbiter_tick_prescaler.sv
// tick_prescaler: divides the system clock down to the timing tick. The tick
// is high during the last count of each period, so with TICK_DIV=1 it is
// high on every cycle, including the first cycle after reset.
module tick_prescaler
  import intersection_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int            CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // Free-running divider counter that wraps after the last count
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= {CW{1'b0}};
    end else if (count == LAST) begin
      count <= {CW{1'b0}};
    end else begin
      count <= count + CW'(1'b1);
    end
  end

  assign tick = (count == LAST);

endmodule

// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter: round-robin green-time arbiter for four
// approaches (0 highway rest, 1 farmway, 2 left-turn, 3 pedestrian) with
// minimum/maximum green, yellow and all-red clearance timing.
// Optional feature: define PREEMPT_EN to add the preempt / preempt_phase
// inputs (emergency-vehicle style forced green).
module intersection_phase_arbiter
  import intersection_pkg::*;
#(
  parameter int TICK_DIV  = 50_000_000,
  parameter int GREEN_MIN = 10,
  parameter int GREEN_MAX = 30,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  sensor,
`ifdef PREEMPT_EN
  input  logic        preempt,
  input  logic [1:0]  preempt_phase,
`endif
  output logic [11:0] lights,
  output logic [1:0]  cur_phase,
  output logic [3:0]  pending
);

  // The dwell timer must hold the longest dwell of any state.
  localparam int TMAX_A = (GREEN_MAX > YELLOW_T) ? GREEN_MAX : YELLOW_T;
  localparam int TMAX   = (TMAX_A > ALLRED_T) ? TMAX_A : ALLRED_T;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] T_MIN      = TW'(GREEN_MIN);
  localparam logic [TW-1:0] T_MIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] T_MAX      = TW'(GREEN_MAX);
  localparam logic [TW-1:0] T_MAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_YEL_LAST = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] T_AR_LAST  = TW'(ALLRED_T - 1);
  localparam logic [TW-1:0] T_SAT      = TW'(TMAX);

  phase_state_t  state;
  phase_state_t  state_next;
  logic [TW-1:0] timer;
  logic [TW-1:0] timer_next;
  logic [TW-1:0] timer_sat;
  logic [1:0]    next_phase;
  logic [1:0]    next_phase_next;
  logic [1:0]    cur_phase_next;
  logic [3:0]    pending_next;
  logic          tick;

  logic [3:0]    green_mask;
  logic [3:0]    req_in;
  logic [3:0]    eff_pending;
  logic          other_pending;
  logic          min_met;
  logic          max_met;
  logic          yellow_done;
  logic          allred_done;
  logic          green_exit;
  logic [1:0]    target;

  logic          pre_on;
  logic [1:0]    pre_ph;

`ifdef PREEMPT_EN
  assign pre_on = preempt;
  assign pre_ph = preempt_phase;
`else
  assign pre_on = 1'b0;
  assign pre_ph = 2'd0;
`endif

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // First requester found searching from+1, from+2, ... modulo 4; 0 if none.
  function automatic logic [1:0] rr_select(input logic [3:0] req, input logic [1:0] from);
    logic [1:0] sel;
    logic [1:0] cand;
    logic       found;
    sel   = 2'd0;
    found = 1'b0;
    for (int k = 1; k < N_APPROACH; k++) begin
      cand = from + 2'(k);
      if (!found && req[cand]) begin
        sel   = cand;
        found = 1'b1;
      end else begin
        sel   = sel;
      end
    end
    return sel;
  endfunction

  // Qualify requests (the green approach's own sensor is ignored) and
  // evaluate the dwell thresholds for the current state
  always_comb begin
    green_mask    = 4'b0000;
    req_in        = 4'b0000;
    eff_pending   = 4'b0000;
    other_pending = 1'b0;
    target        = next_phase;
    if (state == ST_GREEN) begin
      green_mask = phase_onehot(cur_phase);
    end else begin
      green_mask = 4'b0000;
    end
    req_in        = sensor & ~green_mask;
    // A request arriving this cycle already counts toward this cycle's decisions.
    eff_pending   = pending | req_in;
    other_pending = |(eff_pending & ~phase_onehot(cur_phase));
    // Minimum/maximum are "met" once reached, so a saturated timer keeps them true.
    min_met     = (timer >= T_MIN) || (tick && (timer == T_MIN_LAST));
    max_met     = (timer >= T_MAX) || (tick && (timer == T_MAX_LAST));
    yellow_done = tick && (timer == T_YEL_LAST);
    allred_done = tick && (timer == T_AR_LAST);
    if (pre_on) begin
      target = pre_ph;
    end else begin
      target = next_phase;
    end
  end

  // Phase sequencing: green exit decision, next-phase choice, request latch
  always_comb begin
    state_next      = state;
    cur_phase_next  = cur_phase;
    next_phase_next = next_phase;
    pending_next    = eff_pending;
    green_exit      = 1'b0;
    case (state)
      ST_GREEN: begin
        if (pre_on) begin
          green_exit = (pre_ph != cur_phase);
        end else if (cur_phase == 2'd0) begin
          green_exit = min_met && other_pending;
        end else begin
          green_exit = max_met || (min_met && other_pending);
        end
        if (green_exit) begin
          state_next = ST_YELLOW;
          if (pre_on) begin
            next_phase_next = pre_ph;
          end else begin
            next_phase_next = rr_select(eff_pending, cur_phase);
          end
        end else begin
          state_next = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        next_phase_next = target;
        if (yellow_done) begin
          state_next     = ST_ALLRED;
          cur_phase_next = target;
        end else begin
          state_next = ST_YELLOW;
        end
      end
      ST_ALLRED: begin
        next_phase_next = target;
        cur_phase_next  = target;
        if (allred_done) begin
          state_next   = ST_GREEN;
          pending_next = eff_pending & ~phase_onehot(target);
        end else begin
          state_next = ST_ALLRED;
        end
      end
      default: begin
        state_next      = ST_ALLRED;
        cur_phase_next  = 2'd0;
        next_phase_next = 2'd0;
        pending_next    = 4'b0000;
      end
    endcase
  end

  // Dwell timer: restart on every state change, count ticks, saturate
  // (rest green at the minimum, otherwise at the longest dwell)
  always_comb begin
    timer_next = timer;
    if ((state == ST_GREEN) && (cur_phase == 2'd0)) begin
      timer_sat = T_MIN;
    end else begin
      timer_sat = T_SAT;
    end
    if (state_next != state) begin
      timer_next = {TW{1'b0}};
    end else if (tick && (timer < timer_sat)) begin
      timer_next = timer + TW'(1'b1);
    end else begin
      timer_next = timer;
    end
  end

  // State, timer and registered outputs all update on the same edge
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ALLRED;
      timer      <= {TW{1'b0}};
      cur_phase  <= 2'd0;
      next_phase <= 2'd0;
      pending    <= 4'b0000;
      lights     <= LIGHTS_RESET;
    end else begin
      state      <= state_next;
      timer      <= timer_next;
      cur_phase  <= cur_phase_next;
      next_phase <= next_phase_next;
      pending    <= pending_next;
      lights     <= make_lights(state_next, cur_phase_next);
    end
  end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Self-checking bench for intersection_phase_arbiter with a cycle-level
// behavioural reference model (TICK_DIV=1, GREEN_MIN=4, GREEN_MAX=10,
// YELLOW_T=2, ALLRED_T=1). Preemption scenario runs when PREEMPT_EN is defined.
module tb_intersection_phase_arbiter;

  localparam int GMIN = 4;
  localparam int GMAX = 10;
  localparam int YT   = 2;
  localparam int AT   = 1;

  logic        clk;
  logic        rst;
  logic [3:0]  sensor;
  logic [11:0] lights;
  logic [1:0]  cur_phase;
  logic [3:0]  pending;
`ifdef PREEMPT_EN
  logic        preempt;
  logic [1:0]  preempt_phase;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: mode 0 all-red, 1 green, 2 yellow
  int       m_mode;
  int       m_phase;
  int       m_next;
  int       m_elapsed;
  bit [3:0] m_pend;

  intersection_phase_arbiter #(
    .TICK_DIV  (1),
    .GREEN_MIN (GMIN),
    .GREEN_MAX (GMAX),
    .YELLOW_T  (YT),
    .ALLRED_T  (AT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sensor        (sensor),
`ifdef PREEMPT_EN
    .preempt       (preempt),
    .preempt_phase (preempt_phase),
`endif
    .lights        (lights),
    .cur_phase     (cur_phase),
    .pending       (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock with the inputs applied during that cycle.
  task automatic model_step(input bit r, input bit [3:0] s);
    bit [3:0] eff;
    bit       other;
    bit       leave;
    if (r) begin
      m_mode = 0; m_phase = 0; m_next = 0; m_pend = 4'b0000; m_elapsed = 0;
      return;
    end
    eff = m_pend;
    for (int i = 0; i < 4; i++)
      if (s[i] && !(m_mode == 1 && i == m_phase)) eff[i] = 1'b1;
    other = 1'b0;
    for (int i = 0; i < 4; i++)
      if (eff[i] && i != m_phase) other = 1'b1;
    m_pend = eff;
    if (m_mode == 1) begin
      if (m_phase == 0) leave = (m_elapsed + 1 >= GMIN) && other;
      else leave = (m_elapsed + 1 >= GMAX) || ((m_elapsed + 1 >= GMIN) && other);
      if (leave) begin
        m_next = 0;
        for (int k = 3; k >= 1; k--)
          if (eff[(m_phase + k) % 4]) m_next = (m_phase + k) % 4;
        m_mode = 2; m_elapsed = 0;
      end else m_elapsed++;
    end else if (m_mode == 2) begin
      if (m_elapsed + 1 == YT) begin m_mode = 0; m_phase = m_next; m_elapsed = 0; end
      else m_elapsed++;
    end else begin
      if (m_elapsed + 1 == AT) begin
        m_mode = 1; m_phase = m_next; m_pend[m_next] = 1'b0; m_elapsed = 0;
      end else m_elapsed++;
    end
  endtask

  function automatic logic [11:0] model_lights();
    logic [11:0] l;
    for (int i = 0; i < 4; i++) begin
      if (m_mode == 1 && i == m_phase)      l[3*i +: 3] = 3'b001;
      else if (m_mode == 2 && i == m_phase) l[3*i +: 3] = 3'b010;
      else                                  l[3*i +: 3] = 3'b100;
    end
    return l;
  endfunction

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic step(input bit r, input bit [3:0] s);
    rst = r;
    sensor = s;
    @(posedge clk);
    #1;
    model_step(r, s);
  endtask

  // Reset, then leave the bench observing phase-0 green cycle 1.
  task automatic start_green();
    step(1'b1, 4'b0000);
    step(1'b1, 4'b0000);
    step(1'b0, 4'b0000);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 4'b0000);
      n_cmp++;
      if (lights !== 12'h924) begin n_fail++; $display("FAIL reset_lights: got %h want 924", lights); end
      n_cmp++;
      if (pending !== 4'b0000) begin n_fail++; $display("FAIL reset_pending: got %b want 0000", pending); end
      n_cmp++;
      if (cur_phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d want 0", cur_phase); end
    end
    step(1'b0, 4'b0000);
    n_cmp++;
    if (lights !== 12'h921) begin n_fail++; $display("FAIL first_green: got %h want 921", lights); end
    n_cmp++;
    if (cur_phase !== 2'd0) begin n_fail++; $display("FAIL first_phase: got %0d want 0", cur_phase); end
  endtask

  task automatic test_rest_phase();
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 4'b0000);
      n_cmp++;
      if (lights !== 12'h921) begin n_fail++; $display("FAIL rest_hold cyc%0d: got %h want 921", i, lights); end
    end
  endtask

  task automatic test_single_request();
    logic [11:0] exp_l [7];
    exp_l = '{12'h921, 12'h921, 12'h921, 12'h922, 12'h922, 12'h924, 12'h864};
    start_green();
    for (int i = 0; i < 7; i++) begin
      step(1'b0, (i == 0) ? 4'b0100 : 4'b0000);
      n_cmp++;
      if (lights !== exp_l[i]) begin
        n_fail++; $display("FAIL single_req cyc%0d: got %h want %h", i, lights, exp_l[i]);
      end
      n_cmp++;
      if (pending !== m_pend) begin
        n_fail++; $display("FAIL single_req_pend cyc%0d: got %b want %b", i, pending, m_pend);
      end
    end
    n_cmp++;
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL single_req_clear: got %b want 0000", pending); end
  endtask

  task automatic test_round_robin();
    logic [11:0] seg_v [10];
    int          seg_n [10];
    logic [11:0] exp_q [$];
    seg_v = '{12'h921, 12'h922, 12'h924, 12'h90C, 12'h914, 12'h924, 12'h324, 12'h524, 12'h924, 12'h921};
    seg_n = '{3, 2, 1, 4, 2, 1, 10, 2, 1, 1};
    for (int s = 0; s < 10; s++)
      for (int j = 0; j < seg_n[s]; j++) exp_q.push_back(seg_v[s]);
    start_green();
    for (int i = 0; i < exp_q.size(); i++) begin
      step(1'b0, (i == 0) ? 4'b1010 : 4'b0000);
      n_cmp++;
      if (lights !== exp_q[i]) begin
        n_fail++; $display("FAIL round_robin cyc%0d: got %h want %h", i, lights, exp_q[i]);
      end
      if (exp_q[i] == 12'h90C) begin
        n_cmp++;
        if (pending !== 4'b1000) begin
          n_fail++; $display("FAIL rr_pending cyc%0d: got %b want 1000", i, pending);
        end
      end
      n_cmp++;
      if (cur_phase !== m_phase[1:0]) begin
        n_fail++; $display("FAIL rr_phase cyc%0d: got %0d want %0d", i, cur_phase, m_phase);
      end
    end
  endtask

  task automatic test_reset_mid_yellow();
    start_green();
    step(1'b0, 4'b1000);
    for (int i = 0; i < 4; i++) step(1'b0, 4'b0000);
    n_cmp++;
    if (lights !== 12'h922) begin n_fail++; $display("FAIL mid_yellow_pre: got %h want 922", lights); end
    n_cmp++;
    if (pending !== 4'b1000) begin n_fail++; $display("FAIL mid_yellow_pend: got %b want 1000", pending); end
    step(1'b1, 4'b0000);
    n_cmp++;
    if (lights !== 12'h924) begin n_fail++; $display("FAIL mid_yellow_rst: got %h want 924", lights); end
    n_cmp++;
    if (pending !== 4'b0000) begin n_fail++; $display("FAIL mid_yellow_rst_pend: got %b want 0000", pending); end
    n_cmp++;
    if (cur_phase !== 2'd0) begin n_fail++; $display("FAIL mid_yellow_rst_phase: got %0d want 0", cur_phase); end
  endtask

  task automatic test_random();
    bit       r;
    bit [3:0] s;
    step(1'b1, 4'b0000);
    for (int i = 0; i < 1500; i++) begin
      r = ($urandom_range(0, 299) == 0);
      for (int b = 0; b < 4; b++) s[b] = ($urandom_range(0, 11) == 0);
      step(r, s);
      n_cmp++;
      if (lights !== model_lights()) begin
        n_fail++; $display("FAIL rand_lights cyc%0d: got %h want %h", i, lights, model_lights());
      end
      n_cmp++;
      if (cur_phase !== m_phase[1:0]) begin
        n_fail++; $display("FAIL rand_phase cyc%0d: got %0d want %0d", i, cur_phase, m_phase);
      end
      n_cmp++;
      if (pending !== m_pend) begin
        n_fail++; $display("FAIL rand_pending cyc%0d: got %b want %b", i, pending, m_pend);
      end
    end
  endtask

`ifdef PREEMPT_EN
  task automatic test_preempt();
    logic [11:0] want;
    start_green();
    preempt = 1'b1;
    preempt_phase = 2'd3;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 4'b0000);
      if (i < 2) want = 12'h922;
      else if (i == 2) want = 12'h924;
      else want = 12'h324;
      n_cmp++;
      if (lights !== want) begin
        n_fail++; $display("FAIL preempt cyc%0d: got %h want %h", i, lights, want);
      end
    end
    preempt = 1'b0;
    step(1'b0, 4'b0000);
    n_cmp++;
    if (lights !== 12'h524) begin n_fail++; $display("FAIL preempt_release: got %h want 524", lights); end
    step(1'b1, 4'b0000);
  endtask
`endif

  initial begin
    rst = 1'b1;
    sensor = 4'b0000;
`ifdef PREEMPT_EN
    preempt = 1'b0;
    preempt_phase = 2'd0;
`endif
    model_step(1'b1, 4'b0000);
    test_reset();
    test_rest_phase();
    test_single_request();
    test_round_robin();
    test_reset_mid_yellow();
    test_random();
`ifdef PREEMPT_EN
    test_preempt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_arbiter.md
# intersection_phase_arbiter

Green-time arbiter for a four-approach intersection. It extends the two-road sensor-driven light controller to four approaches: 0 = highway rest phase, 1 = farmway, 2 = left-turn, 3 = pedestrian. Each approach raises a sensor request. The block grants green to one approach at a time, round-robin, with minimum and maximum green, yellow and all-red clearance timing. It sits between the road/pedestrian sensors and the lamp drivers, and is clocked from the 50 MHz system clock.

## Interface
- `TICK_DIV`, default 50_000_000: clock cycles per timing tick (1 s at 50 MHz). Set to 1 in simulation.
- `GREEN_MIN`, default 10: minimum green, in ticks. Must be ≥1.
- `GREEN_MAX`, default 30: maximum green for a non-rest phase, in ticks. Must be ≥ `GREEN_MIN`.
- `YELLOW_T`, default 3: yellow duration, in ticks. Must be ≥1.
- `ALLRED_T`, default 1: all-red clearance, in ticks. Must be ≥1.
- `clk`, input, 1: system clock. The block uses one clock.
- `rst`, input, 1: synchronous, active-high reset.
- `sensor`, input, 4: per-approach request. Level or pulse; sampled every cycle.
- `lights`, output, 12: lamp state of approach i at `[3i+2:3i]`. Encoding: 3'b100 red, 3'b010 yellow, 3'b001 green.
- `cur_phase`, output, 2: approach currently owning the intersection (green, yellow, or next up during all-red).
- `pending`, output, 4: latched, unserved requests.

## Operation
- States: `ALLRED`, `GREEN`, `YELLOW`.
  - In `GREEN` and `YELLOW`, `cur_phase` shows green or yellow; all other approaches are red.
  - In `ALLRED`, all approaches are red.
- Request latching:
  - `pending[i]` is set when `sensor[i]`=1, except while approach i is in `GREEN`. Those requests are ignored.
  - `pending[i]` is cleared on the cycle approach i enters `GREEN`.
- `GREEN` exit, for phase 0 (rest phase):
  - Exits after `GREEN_MIN` ticks, as soon as any `pending` bit is set.
  - Otherwise holds indefinitely. There is no maximum.
- `GREEN` exit, for phase p≠0:
  - Exits after `GREEN_MIN` ticks if any other `pending` bit is set.
  - Otherwise exits after `GREEN_MAX` ticks.
- Next-phase selection:
  - Made on the cycle `GREEN` exits, and stored in `next_phase`.
  - Round-robin: the first pending approach searching p+1, p+2, … modulo 4.
  - If nothing is pending, the next phase is 0.
- Sequence: `GREEN` → `YELLOW` (`YELLOW_T` ticks) → `ALLRED` (`ALLRED_T` ticks) → `GREEN` of `next_phase`. `cur_phase` updates on entry to `ALLRED`.
- Reset gives:
  - state `ALLRED`, timer 0, prescaler 0;
  - `cur_phase`=0, `next_phase`=0;
  - `pending`=0;
  - `lights`=12'h924.
- The first green after reset is phase 0 (12'h921).
- Reset mid-operation forces all of the above on the next edge. Every in-progress interval is abandoned.

## Timing
- Prescaler:
  - Counts 0…`TICK_DIV`-1 and pulses `tick` for one cycle when it wraps.
  - With `TICK_DIV`=1, `tick` is high every cycle.
- Dwell timer:
  - Cleared on every state entry; increments on `tick`.
  - A state with dwell N exits in the cycle where `tick`=1 and timer==N-1. The new state is registered on the next edge.
  - Timer width is $clog2(`GREEN_MAX`+1). Phase-0 rest saturates at `GREEN_MIN`.
- Outputs are registered. `lights`, `cur_phase` and `pending` change on the same edge as the state.
- `sensor` to `pending`: 1 cycle.
- A `sensor` edge and a `GREEN` exit in the same cycle: the new request counts toward this cycle's exit decision and next-phase selection.

## Configuration
- `PREEMPT_EN` defined:
  - Adds input `preempt` (1 bit) and input `preempt_phase` (2 bits).
  - While `preempt`=1 and `cur_phase`≠`preempt_phase` in `GREEN`: go to `YELLOW` on the next edge, ignoring `GREEN_MIN`. Then `next_phase`=`preempt_phase`.
  - While `preempt`=1 in `GREEN` of `preempt_phase`: hold green, ignoring `GREEN_MAX` and `pending`.
  - On release of `preempt`, normal rules resume with the timer unchanged.
  - `preempt` during `YELLOW` or `ALLRED` overrides `next_phase`.
- `PREEMPT_EN` undefined: neither port exists, and the logic is absent.

## Structure
- Package `intersection_pkg` holds:
  - light encodings (`LIGHT_RED`, `LIGHT_YELLOW`, `LIGHT_GREEN`);
  - state enum;
  - `N_APPROACH`=4;
  - the reset lights constant 12'h924.
- Sub-module `tick_prescaler`, parameter `TICK_DIV`, with ports `clk`, `rst`, `tick`.
- The FSM, request latch and round-robin selector stay in the top module.

## Test plan
All scenarios use `TICK_DIV`=1, `GREEN_MIN`=4, `GREEN_MAX`=10, `YELLOW_T`=2, `ALLRED_T`=1.

1. **Reset.**
   - Stimulus: `rst`=1 for 3 cycles, then release.
   - Required: `lights`=12'h924 and `pending`=0 during reset. After 1 cycle of all-red, `lights`=12'h921 and `cur_phase`=0.
2. **Rest phase.**
   - Stimulus: no sensors for 100 cycles.
   - Required: `lights` stays 12'h921.
3. **Single request.**
   - Stimulus: pulse `sensor[2]` for 1 cycle at phase-0 green cycle 1.
   - Required: green lasts 4 cycles, then 12'h922 for 2 cycles, 12'h924 for 1 cycle, then 12'h864 with `pending`=0.
4. **Round-robin.**
   - Stimulus: assert `sensor[1]` and `sensor[3]` together during phase-0 green.
   - Required: phase 1 gets 4 green cycles (3 still pending), then phase 3 gets 10 green cycles (nothing pending), then phase 0 (12'h921).
5. **Reset mid-yellow.**
   - Stimulus: assert `rst` in the second yellow cycle, with `pending`=4'b1000.
   - Required: next edge gives 12'h924, `pending`=0 and `cur_phase`=0.
6. **Preemption (`PREEMPT_EN`).**
   - Stimulus: `preempt`=1 with `preempt_phase`=3 at phase-0 green cycle 1; release after 20 cycles.
   - Required: yellow on the next edge, phase 3 green (12'h324) held until release, then phase 3 exits at `GREEN_MAX` or `GREEN_MIN` per the normal rules.
